// File: rtl/id_stage_pipe.sv
// Decode stage: register file, two-word immediate assembly, load-use stall and
// flush handling, registered ID/EX outputs. Optional macro: ID_WB_BYPASS_EN.
module id_stage_pipe #(
  parameter int          WIDTH     = 16,
  parameter int          REG_AW    = 3,
  parameter logic [1:0]  IMM_CLASS = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_instr,
  output logic              stall_o,
  input  logic              load_use,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              ex_valid,
  output logic [4:0]        ex_opcode,
  output logic [WIDTH-1:0]  ex_op1,
  output logic [WIDTH-1:0]  ex_op2,
  output logic [WIDTH-1:0]  ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_two_word,
  output logic              dbg_state_o
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic {
    S_DEC = 1'b0,
    S_IMM = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [4:0]        opcode;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic [WIDTH-1:0]  imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rd;
    logic              two_word;
  } idex_t;

  typedef struct packed {
    logic [4:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rd;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
  } hold_t;

  state_t            state_q, state_d;
  idex_t             idex_q, idex_d;
  hold_t             hold_q, hold_d;
  logic [WIDTH-1:0]  rf_q [NREG];
  logic [WIDTH-1:0]  rf_d [NREG];

  logic [4:0]        dec_opcode;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rd;
  logic [WIDTH-1:0]  rd1_val;
  logic [WIDTH-1:0]  rd2_val;

  assign dec_opcode = in_instr[WIDTH-1 -: 5];
  assign dec_rs1    = in_instr[WIDTH-6 -: REG_AW];
  assign dec_rd     = in_instr[WIDTH-6-REG_AW -: REG_AW];

  always_comb begin
    rd1_val = rf_q[dec_rs1];
    rd2_val = rf_q[dec_rd];
`ifdef ID_WB_BYPASS_EN
    if (wb_en && (wb_addr == dec_rs1)) rd1_val = wb_data;
    if (wb_en && (wb_addr == dec_rd))  rd2_val = wb_data;
`endif
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[wb_addr] = wb_data;
  end

  // Handshake: fetch offers a word with in_valid; the word is consumed on the
  // next rising edge unless stall_o (load-use in S_DEC) or flush is high.
  assign stall_o = (state_q == S_DEC) && load_use && !flush;

  always_comb begin
    state_d = state_q;
    idex_d  = '0;
    hold_d  = hold_q;
    if (flush) begin
      state_d = S_DEC;
      hold_d  = '0;
    end else if (state_q == S_DEC) begin
      if (!load_use && in_valid) begin
        if (dec_opcode[4:3] == IMM_CLASS) begin
          hold_d.opcode = dec_opcode;
          hold_d.rs1    = dec_rs1;
          hold_d.rd     = dec_rd;
          hold_d.op1    = rd1_val;
          hold_d.op2    = rd2_val;
          state_d       = S_IMM;
        end else begin
          idex_d.valid  = 1'b1;
          idex_d.opcode = dec_opcode;
          idex_d.op1    = rd1_val;
          idex_d.op2    = rd2_val;
          idex_d.rs1    = dec_rs1;
          idex_d.rd     = dec_rd;
        end
      end
    end else if (in_valid) begin
      // Operands were captured with the first word, so load_use is moot here.
      idex_d.valid    = 1'b1;
      idex_d.opcode   = hold_q.opcode;
      idex_d.op1      = hold_q.op1;
      idex_d.op2      = hold_q.op2;
      idex_d.imm      = in_instr;
      idex_d.rs1      = hold_q.rs1;
      idex_d.rd       = hold_q.rd;
      idex_d.two_word = 1'b1;
      state_d         = S_DEC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_DEC;
      idex_q  <= '0;
      hold_q  <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
      hold_q  <= hold_d;
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign ex_valid    = idex_q.valid;
  assign ex_opcode   = idex_q.opcode;
  assign ex_op1      = idex_q.op1;
  assign ex_op2      = idex_q.op2;
  assign ex_imm      = idex_q.imm;
  assign ex_rs1      = idex_q.rs1;
  assign ex_rd       = idex_q.rd;
  assign ex_two_word = idex_q.two_word;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: expected ID/EX contents queued at drive
// time and compared one edge later.
module tb_id_stage_pipe;

  localparam int W  = 16;
  localparam int AW = 3;
  localparam int EW = 1 + 5 + 3*W + 2*AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_instr;
  logic          stall_o;
  logic          load_use;
  logic          flush;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          ex_valid;
  logic [4:0]    ex_opcode;
  logic [W-1:0]  ex_op1, ex_op2, ex_imm;
  logic [AW-1:0] ex_rs1, ex_rd;
  logic          ex_two_word;
  logic          dbg_state;

  logic [EW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [W-1:0]  model [8];
  logic [W-1:0]  byp_exp;

  id_stage_pipe #(.WIDTH(W), .REG_AW(AW), .IMM_CLASS(2'b11)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .stall_o(stall_o), .load_use(load_use), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rd(ex_rd),
    .ex_two_word(ex_two_word), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [4:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b);
    return {op, a, b, 5'b0};
  endfunction

  function automatic logic [EW-1:0] ev(input logic v, input logic [4:0] op, input logic [W-1:0] o1,
                                       input logic [W-1:0] o2, input logic [W-1:0] imm,
                                       input logic [AW-1:0] a, input logic [AW-1:0] b, input logic tw);
    return {v, op, o1, o2, imm, a, b, tw};
  endfunction

  function automatic logic [EW-1:0] observed();
    return {ex_valid, ex_opcode, ex_op1, ex_op2, ex_imm, ex_rs1, ex_rd, ex_two_word};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] instr, input logic lu, input logic fl,
                       input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd);
    @(negedge clk);
    in_valid = v;  in_instr = instr; load_use = lu; flush = fl;
    wb_en    = we; wb_addr  = wa;    wb_data  = wd;
  endtask

  // One cycle: drive, check stall, push expectation, compare after the edge.
  task automatic step(input string tag, input logic v, input logic [W-1:0] instr, input logic lu,
                      input logic fl, input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                      input logic [EW-1:0] exp, input logic exp_stall);
    logic [EW-1:0] e;
    drive(v, instr, lu, fl, we, wa, wd);
    #1;
    chk({tag, "_stall"}, {63'd0, stall_o}, {63'd0, exp_stall});
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {3'd0, observed()}, {3'd0, e});
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
`ifdef ID_WB_BYPASS_EN
    byp_exp = 16'h00AA;
`else
    byp_exp = 16'h0000;
`endif
    rst = 1'b0;
    in_valid = 1'b0; in_instr = '0; load_use = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex", {3'd0, observed()}, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_state", {63'd0, dbg_state}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: one-word instruction reading a written register
    step("t1_wb", 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, '0, 1'b0);
    step("t1_issue", 1'b1, mk(5'b00010, 3'd3, 3'd0), 1'b0, 1'b0, 1'b0, '0, '0,
         ev(1, 5'b00010, 16'h1234, 16'h0000, 16'h0000, 3'd3, 3'd0, 0), 1'b0);

    // 2: two-word instruction with a gap and load_use during the immediate word
    step("t2_wb", 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'd5, 16'h5A5A, '0, 1'b0);
    step("t2_w1", 1'b1, mk(5'b11000, 3'd3, 3'd5), 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("t2_state_imm", {63'd0, dbg_state}, 64'd1);
    idle("t2_gap");
    step("t2_w2", 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, '0, '0,
         ev(1, 5'b11000, 16'h1234, 16'h5A5A, 16'hBEEF, 3'd3, 3'd5, 1), 1'b0);
    chk("t2_state_dec", {63'd0, dbg_state}, 64'd0);

    // 3: load-use stall for two cycles
    step("t3_lu0", 1'b1, mk(5'b00100, 3'd5, 3'd3), 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    step("t3_lu1", 1'b1, mk(5'b00100, 3'd5, 3'd3), 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    step("t3_go", 1'b1, mk(5'b00100, 3'd5, 3'd3), 1'b0, 1'b0, 1'b0, '0, '0,
         ev(1, 5'b00100, 16'h5A5A, 16'h1234, 16'h0000, 3'd5, 3'd3, 0), 1'b0);

    // 4: flush in S_IMM, then a fresh one-word decode; flush in S_DEC
    step("t4_w1", 1'b1, mk(5'b11001, 3'd3, 3'd3), 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    step("t4_flush", 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    chk("t4_state", {63'd0, dbg_state}, 64'd0);
    step("t4_fresh", 1'b1, 16'h0800, 1'b0, 1'b0, 1'b0, '0, '0,
         ev(1, 5'b00001, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0, 0), 1'b0);
    step("t4_flush_dec", 1'b1, mk(5'b00010, 3'd3, 3'd5), 1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0);

    // 5: same-cycle writeback vs decode read; register 0 is writable
    step("t5_same", 1'b1, mk(5'b00011, 3'd2, 3'd2), 1'b0, 1'b0, 1'b1, 3'd2, 16'h00AA,
         ev(1, 5'b00011, byp_exp, byp_exp, 16'h0000, 3'd2, 3'd2, 0), 1'b0);
    step("t5_after", 1'b1, mk(5'b00011, 3'd2, 3'd0), 1'b0, 1'b0, 1'b0, '0, '0,
         ev(1, 5'b00011, 16'h00AA, 16'h0000, 16'h0000, 3'd2, 3'd0, 0), 1'b0);
    step("t5_wb_r0", 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h7777, '0, 1'b0);
    step("t5_rd_r0", 1'b1, mk(5'b00010, 3'd0, 3'd5), 1'b0, 1'b0, 1'b0, '0, '0,
         ev(1, 5'b00010, 16'h7777, 16'h5A5A, 16'h0000, 3'd0, 3'd5, 0), 1'b0);

    // 6: asynchronous reset in the middle of a two-word sequence
    step("t6_w1", 1'b1, mk(5'b11000, 3'd3, 3'd5), 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_ex", {3'd0, observed()}, 64'd0);
    chk("t6_rst_state", {63'd0, dbg_state}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step("t6_imm_as_one", 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, '0, '0,
         ev(1, 5'b10111, 16'h0000, 16'h0000, 16'h0000, 3'd6, 3'd7, 0), 1'b0);
    step("t6_rf_clr", 1'b1, mk(5'b00010, 3'd3, 3'd5), 1'b0, 1'b0, 1'b0, '0, '0,
         ev(1, 5'b00010, 16'h0000, 16'h0000, 16'h0000, 3'd3, 3'd5, 0), 1'b0);

    // Random register contents read back through both ports
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int i = 1; i < 8; i++) begin
      model[i] = W'($urandom_range(1, 16'hFFFF));
      step("rnd_wb", 1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(i), model[i], '0, 1'b0);
    end
    for (int i = 1; i < 8; i++) begin
      int j;
      j = (i % 7) + 1;
      step("rnd_rd", 1'b1, mk(5'b00101, AW'(i), AW'(j)), 1'b0, 1'b0, 1'b0, '0, '0,
           ev(1, 5'b00101, model[i], model[j], 16'h0000, AW'(i), AW'(j), 0), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
